// File: rtl/sopc_video_led_pio_if.sv
// Avalon-MM slave bus bundle for the video LED output PIO.
`timescale 1ns/1ps

interface sopc_video_led_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/sopc_video_led_pio.sv
// Avalon-MM output PIO driving the status LEDs, with per-bit blink masking from a prescaler.
// Define BIT_SET_CLEAR_EN to build the atomic OUTSET (addr 4) / OUTCLEAR (addr 5) registers.
`timescale 1ns/1ps

module sopc_video_led_pio #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter logic [31:0] RESET_VALUE  = 32'h0,
    parameter int unsigned PERIOD_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    sopc_video_led_pio_if.slave    bus,
    output logic [DATA_WIDTH-1:0]  out_port
);

    localparam logic [DATA_WIDTH-1:0] DataRst = RESET_VALUE[DATA_WIDTH-1:0];

    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   mask_q, mask_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic                    phase_q, phase_d;
    logic [DATA_WIDTH-1:0]   out_q, out_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    wr_en;
    logic [DATA_WIDTH-1:0]   wd_data;
    logic                    unused_wd;

    assign wr_en     = bus.chipselect & ~bus.write_n;
    assign wd_data   = bus.writedata[DATA_WIDTH-1:0];
    assign unused_wd = ^bus.writedata;

    always_comb begin
        data_d   = data_q;
        mask_d   = mask_q;
        period_d = period_q;
        if (wr_en) begin
            case (bus.address)
                3'd0: data_d   = wd_data;
                3'd1: mask_d   = wd_data;
                3'd2: period_d = bus.writedata[PERIOD_WIDTH-1:0];
`ifdef BIT_SET_CLEAR_EN
                3'd4: data_d   = data_q | wd_data;
                3'd5: data_d   = data_q & ~wd_data;
`endif
                default: ;
            endcase
        end
    end

    // A PERIOD write restarts the count so cnt can never overrun a smaller period.
    always_comb begin
        cnt_d   = cnt_q + PERIOD_WIDTH'(1);
        phase_d = phase_q;
        if (wr_en && bus.address == 3'd2) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (period_q == '0) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == period_q) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    assign out_d = data_q & (~mask_q | {DATA_WIDTH{phase_q}});

    always_comb begin
        rdata_d = '0;
        case (bus.address)
            3'd0: rdata_d[DATA_WIDTH-1:0]   = data_q;
            3'd1: rdata_d[DATA_WIDTH-1:0]   = mask_q;
            3'd2: rdata_d[PERIOD_WIDTH-1:0] = period_q;
            3'd3: rdata_d[DATA_WIDTH-1:0]   = out_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= DataRst;
            mask_q   <= '0;
            period_q <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b1;
            out_q    <= DataRst;
            rdata_q  <= '0;
        end else begin
            data_q   <= data_d;
            mask_q   <= mask_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            out_q    <= out_d;
            rdata_q  <= rdata_d;
        end
    end

    assign out_port     = out_q;
    assign bus.readdata = rdata_q;

endmodule

// File: tb/tb_sopc_video_led_pio.sv
// Directed self-checking bench for sopc_video_led_pio (RESET_VALUE = 8'hA5).
`timescale 1ns/1ps

module tb_sopc_video_led_pio;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] out_port;
    logic [31:0] rd;
    int checks = 0;
    int errors = 0;

    sopc_video_led_pio_if bus_if ();

    sopc_video_led_pio #(
        .DATA_WIDTH   (8),
        .RESET_VALUE  (32'h0000_00A5),
        .PERIOD_WIDTH (16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus_if),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Write strobe is held across exactly one rising edge; returns on the following negedge.
    task automatic bus_write(input logic [2:0] addr, input logic [31:0] wd, input logic cs = 1'b1);
        @(negedge clk);
        bus_if.address    = addr;
        bus_if.writedata  = wd;
        bus_if.chipselect = cs;
        bus_if.write_n    = 1'b0;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
        @(negedge clk);
        bus_if.address    = addr;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b1;
        @(negedge clk);
        data = bus_if.readdata;
        bus_if.chipselect = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp8;
        reset_n           = 1'b0;
        bus_if.address    = 3'd0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_out", {24'h0, out_port}, 32'hA5);
        check_eq("rst_rdata", bus_if.readdata, 32'h0);
        reset_n = 1'b1;
        bus_read(3'd0, rd);
        check_eq("rst_data_rd", rd, 32'h0000_00A5);

        // DATA write, upper bits dropped, two-edge output latency
        bus_write(3'd0, 32'hFFFF_FF3C);
        check_eq("data_lat1", {24'h0, out_port}, 32'hA5);
        @(negedge clk);
        check_eq("data_lat2", {24'h0, out_port}, 32'h3C);
        bus_read(3'd0, rd);
        check_eq("data_rd", rd, 32'h3C);

        // MASK / PERIOD readback widths
        bus_write(3'd1, 32'hFFFF_FF5A);
        bus_read(3'd1, rd);
        check_eq("mask_rd", rd, 32'h5A);
        bus_write(3'd2, 32'h0001_2345);
        bus_read(3'd2, rd);
        check_eq("period_rd", rd, 32'h2345);
        bus_write(3'd2, 32'h0);
        bus_write(3'd1, 32'h0);
        bus_read(3'd3, rd);
        check_eq("out_status", rd, 32'h3C);

        // Blink: half-period of 4 cycles on the low nibble
        bus_write(3'd0, 32'hFF);
        bus_write(3'd1, 32'h0F);
        bus_write(3'd2, 32'd3);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            exp8 = (((i - 1) / 4) % 2 == 0) ? 8'hFF : 8'hF0;
            check_eq($sformatf("blink_%0d", i), {24'h0, out_port}, {24'h0, exp8});
        end
        bus_write(3'd2, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq($sformatf("steady_%0d", i), {24'h0, out_port}, 32'hFF);
        end

        // Period rewrite with cnt==7 restarts count: toggles after 3 cycles
        bus_write(3'd2, 32'd10);
        repeat (6) @(negedge clk);
        bus_write(3'd2, 32'd2);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp8 = (k >= 4 && k <= 6) ? 8'hF0 : 8'hFF;
            check_eq($sformatf("rewrite_%0d", k), {24'h0, out_port}, {24'h0, exp8});
        end
        bus_write(3'd2, 32'd0);
        bus_write(3'd1, 32'd0);

        // Atomic set / clear
        bus_write(3'd0, 32'h0F);
        bus_write(3'd4, 32'h30);
        bus_read(3'd0, rd);
`ifdef BIT_SET_CLEAR_EN
        check_eq("outset", rd, 32'h3F);
`else
        check_eq("outset", rd, 32'h0F);
`endif
        bus_write(3'd5, 32'h03);
        bus_read(3'd0, rd);
`ifdef BIT_SET_CLEAR_EN
        check_eq("outclear", rd, 32'h3C);
`else
        check_eq("outclear", rd, 32'h0F);
`endif
        @(negedge clk);
`ifdef BIT_SET_CLEAR_EN
        check_eq("sc_out", {24'h0, out_port}, 32'h3C);
`else
        check_eq("sc_out", {24'h0, out_port}, 32'h0F);
`endif
        bus_read(3'd4, rd);
        check_eq("rd_addr4", rd, 32'h0);
        bus_read(3'd5, rd);
        check_eq("rd_addr5", rd, 32'h0);

        // Reserved address and unselected writes leave state alone
        bus_write(3'd0, 32'h66);
        bus_write(3'd6, 32'hFF);
        bus_write(3'd0, 32'h99, 1'b0);
        bus_write(3'd1, 32'hFF, 1'b0);
        bus_read(3'd0, rd);
        check_eq("no_cs_data", rd, 32'h66);
        bus_read(3'd1, rd);
        check_eq("no_cs_mask", rd, 32'h0);
        bus_read(3'd6, rd);
        check_eq("rd_addr6", rd, 32'h0);
        bus_read(3'd7, rd);
        check_eq("rd_addr7", rd, 32'h0);

        // Asynchronous reset mid-blink, checked between clock edges
        bus_write(3'd0, 32'hFF);
        bus_write(3'd1, 32'h0F);
        bus_write(3'd2, 32'd1);
        repeat (5) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_out", {24'h0, out_port}, 32'hA5);
        check_eq("async_rdata", bus_if.readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(3'd0, rd);
        check_eq("async_data", rd, 32'hA5);
        bus_read(3'd1, rd);
        check_eq("async_mask", rd, 32'h0);
        bus_read(3'd2, rd);
        check_eq("async_period", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
